// File: rtl/filters_pkg.sv
// Shared helpers for the filters datapath: rail-code construction and shift clamping.
package filters_pkg;

   // Positive rail of a w-bit two's complement code: 0 followed by all ones.
   function automatic logic [31:0] rail_pos(input int w);
      return (32'd1 << (w - 1)) - 32'd1;
   endfunction

   // Negative rail of a w-bit two's complement code: 1 followed by all zeros.
   function automatic logic [31:0] rail_neg(input int w);
      return 32'd1 << (w - 1);
   endfunction

   function automatic int max_shift(input int iw, input int ow);
      return ow - iw;
   endfunction

   function automatic int unsigned clamp_shift(input int unsigned sh, input int unsigned max_sh);
      return (sh > max_sh) ? max_sh : sh;
   endfunction

endpackage

// File: rtl/filters_pipe_stage.sv
// Valid/ready register slice without skid buffer; ready passes straight through from downstream.
module filters_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);
   logic         valid_q;
   logic [W-1:0] data_q;
   logic         load;

   assign load        = !valid_q || out_ready_i;
   assign in_ready_o  = load;
   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load) begin
         valid_q <= in_valid_i;
         if (in_valid_i) data_q <= in_data_i;
      end
   end
endmodule

// File: rtl/filters_expand.sv
// Widening stage: sign-extend, clamp-shift left, flag and count rail codes.
// Optional macro FILTERS_EXPAND_ROUND_EN sets the half-LSB bit on non-rail shifted samples.
module filters_expand
   import filters_pkg::*;
#(
   parameter int IW   = 9,
   parameter int OW   = 16,
   parameter int SHW  = 3,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SHW-1:0]  shift_i,
   input  logic            clear_i,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IW-1:0]   in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OW-1:0]   out_data,
   output logic            out_clip,
   output logic [CNTW-1:0] clip_cnt
);
   localparam int            MAX_SHIFT = max_shift(IW, OW);
   localparam logic [IW-1:0] RAIL_POS  = IW'(rail_pos(IW));
   localparam logic [IW-1:0] RAIL_NEG  = IW'(rail_neg(IW));
   localparam int            S1W       = SHW + 1 + OW;
   localparam int            S2W       = 1 + OW;
   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic           in_rail;
   logic [SHW-1:0] shift_eff;
   logic [OW-1:0]  in_ext;

   assign in_rail   = (in_data == RAIL_POS) || (in_data == RAIL_NEG);
   assign shift_eff = SHW'(clamp_shift(32'(shift_i), 32'(MAX_SHIFT)));
   assign in_ext    = {{(OW-IW){in_data[IW-1]}}, in_data};

   logic           s1_valid;
   logic           s2_in_ready;
   logic [S1W-1:0] s1_payload;

   filters_pipe_stage #(.W(S1W)) u_s1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   ({shift_eff, in_rail, in_ext}),
      .out_valid_o (s1_valid),
      .out_ready_i (s2_in_ready),
      .out_data_o  (s1_payload)
   );

   logic [SHW-1:0] s1_shift;
   logic           s1_rail;
   logic [OW-1:0]  s1_ext;
   logic [OW-1:0]  shifted;

   assign s1_shift = s1_payload[S1W-1 -: SHW];
   assign s1_rail  = s1_payload[OW];
   assign s1_ext   = s1_payload[OW-1:0];

   // The clamp guarantees the shift never pushes significant bits past the MSB.
   always_comb begin
      shifted = s1_ext << s1_shift;
`ifdef FILTERS_EXPAND_ROUND_EN
      if ((s1_shift != '0) && !s1_rail)
         shifted = shifted | ((OW'(1) << s1_shift) >> 1);
`endif
   end

   logic [S2W-1:0] s2_payload;

   filters_pipe_stage #(.W(S2W)) u_s2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (s1_valid),
      .in_ready_o  (s2_in_ready),
      .in_data_i   ({s1_rail, shifted}),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (s2_payload)
   );

   assign out_clip = s2_payload[OW];
   assign out_data = s2_payload[OW-1:0];

   logic            count_ev;
   logic [CNTW-1:0] clip_cnt_q;
   logic [CNTW-1:0] clip_cnt_d;

   assign count_ev = in_valid && in_ready && in_rail;

   // Clear wins, but a rail transfer in the same cycle is still counted.
   always_comb begin
      clip_cnt_d = clip_cnt_q;
      if (clear_i)
         clip_cnt_d = count_ev ? CNTW'(1) : '0;
      else if (count_ev && (clip_cnt_q != CNT_MAX))
         clip_cnt_d = clip_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) clip_cnt_q <= '0;
      else        clip_cnt_q <= clip_cnt_d;
   end

   assign clip_cnt = clip_cnt_q;
endmodule
